// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial-to-parallel word controller.
package serial_word_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift storage; new bits enter at bit 0 and move upward.
module shift_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Shift storage: clears on reset, shifts one bit in when enabled, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (en) begin
      q_r <= {q_r[WIDTH-2:0], d};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/serial_word_ctrl.sv
// Collects WIDTH serial bits into a word, presents it with a valid/ready
// handshake, and flags bits that arrive while a finished word is pending.
module serial_word_ctrl
  import serial_word_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             serial_i,
  input  logic             bit_valid_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             overrun_r;
  logic             overrun_next_s;
  logic             shift_en_s;
  logic             reset_n_s;

  // Next-state, counter and shift-enable decode; abort outranks an offered bit.
  always_comb begin
    state_next_s   = state_r;
    count_next_s   = count_r;
    shift_en_s     = 1'b0;
    overrun_next_s = 1'b0;
    if (reset) begin
      state_next_s = IDLE;
      count_next_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_next_s = SHIFT;
            count_next_s = {CNT_W{1'b0}};
          end else begin
            state_next_s = IDLE;
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state_next_s = IDLE;
            count_next_s = {CNT_W{1'b0}};
          end else if (bit_valid_i) begin
            shift_en_s = 1'b1;
            if (count_r == LAST_BIT) begin
              state_next_s = HOLD;
              count_next_s = {CNT_W{1'b0}};
            end else begin
              count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_next_s = SHIFT;
          end
        end
        HOLD: begin
          // Any bit offered while a word waits is lost, whatever else happens.
          overrun_next_s = bit_valid_i;
          if (abort_i) begin
            state_next_s = IDLE;
          end else if (word_ready_i) begin
            if (start_i) begin
              state_next_s = SHIFT;
              count_next_s = {CNT_W{1'b0}};
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            state_next_s = HOLD;
          end
        end
        default: begin
          state_next_s = IDLE;
          count_next_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter and overrun pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      count_r   <= count_next_s;
      overrun_r <= overrun_next_s;
    end
  end

  assign reset_n_s = ~reset;

  shift_register #(
    .WIDTH (WIDTH)
  ) shift_register (
    .clk   (clk),
    .rst_n (reset_n_s),
    .en    (shift_en_s),
    .d     (serial_i),
    .q     (word_o)
  );

  assign shift_en_o   = shift_en_s;
  assign word_valid_o = (state_r == HOLD);
  assign busy_o       = (state_r != IDLE);
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_serial_word_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a word-level model.
module tb_serial_word_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         serial_i = 1'b0;
  logic         bit_valid_i = 1'b0;
  logic         word_ready_i = 1'b0;
  logic [W-1:0] word_o;
  logic         word_valid_o;
  logic         shift_en_o;
  logic         busy_o;
  logic         overrun_o;

  int checks = 0;
  int errors = 0;

  // Model: collecting a word, holding a finished word, bits gathered so far.
  bit           m_collecting = 1'b0;
  bit           m_pending = 1'b0;
  int           m_nbits = 0;
  logic [W-1:0] m_word = '0;
  bit           m_overrun = 1'b0;

  serial_word_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .serial_i     (serial_i),
    .bit_valid_i  (bit_valid_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .shift_en_o   (shift_en_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_collecting = 1'b0;
      m_pending    = 1'b0;
      m_nbits      = 0;
      m_word       = '0;
      m_overrun    = 1'b0;
    end else begin
      m_overrun = m_pending && bit_valid_i;
      if (m_collecting) begin
        if (abort_i) begin
          m_collecting = 1'b0;
          m_nbits      = 0;
        end else if (bit_valid_i) begin
          m_word  = (m_word << 1) | W'(serial_i);
          m_nbits = m_nbits + 1;
          if (m_nbits == W) begin
            m_collecting = 1'b0;
            m_pending    = 1'b1;
            m_nbits      = 0;
          end
        end
      end else if (m_pending) begin
        if (abort_i) begin
          m_pending = 1'b0;
        end else if (word_ready_i) begin
          m_pending = 1'b0;
          if (start_i) begin
            m_collecting = 1'b1;
            m_nbits      = 0;
          end
        end
      end else if (start_i) begin
        m_collecting = 1'b1;
        m_nbits      = 0;
      end
    end
  end

  // Compare all outputs against the model mid-cycle.
  always @(negedge clk) begin
    check("word_o", 32'(word_o), 32'(m_word));
    check("word_valid_o", 32'(word_valid_o), 32'(m_pending));
    check("busy_o", 32'(busy_o), 32'(m_collecting || m_pending));
    check("overrun_o", 32'(overrun_o), 32'(m_overrun));
    check("shift_en_o", 32'(shift_en_o),
          32'(!reset && m_collecting && bit_valid_i && !abort_i));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] data, input int n, input bit gap);
    for (int i = W - 1; i >= W - n; i--) begin
      serial_i    = data[i];
      bit_valid_i = 1'b1;
      step();
      bit_valid_i = 1'b0;
      if (gap) step();
    end
    bit_valid_i = 1'b0;
  endtask

  task automatic release_word();
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    check("reset word_o", 32'(word_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);

    // Basic word, ready already high.
    pulse_start();
    word_ready_i = 1'b1;
    send_bits(16'hA5C3, W, 1'b0);
    check("basic valid", 32'(word_valid_o), 32'h1);
    check("basic word", 32'(word_o), 32'h0000A5C3);
    step();
    word_ready_i = 1'b0;
    check("basic idle", 32'(busy_o), 32'h0);
    check("basic word kept", 32'(word_o), 32'h0000A5C3);

    // Gapped bits with back-pressure.
    pulse_start();
    send_bits(16'h1234, W, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp valid", 32'(word_valid_o), 32'h1);
      check("bp word", 32'(word_o), 32'h00001234);
      step();
    end
    release_word();
    check("bp released", 32'(word_valid_o), 32'h0);

    // Overrun while holding.
    pulse_start();
    send_bits(16'h5A5A, W, 1'b0);
    serial_i    = 1'b1;
    bit_valid_i = 1'b1;
    step();
    check("ovr first", 32'(overrun_o), 32'h1);
    step();
    bit_valid_i = 1'b0;
    check("ovr second", 32'(overrun_o), 32'h1);
    check("ovr word", 32'(word_o), 32'h00005A5A);
    step();
    check("ovr end", 32'(overrun_o), 32'h0);
    release_word();

    // Abort after seven bits, with a bit offered on the abort cycle.
    pulse_start();
    send_bits(16'h0000, 7, 1'b0);
    abort_i     = 1'b1;
    bit_valid_i = 1'b1;
    serial_i    = 1'b1;
    step();
    abort_i     = 1'b0;
    bit_valid_i = 1'b0;
    check("abort idle", 32'(busy_o), 32'h0);
    check("abort novalid", 32'(word_valid_o), 32'h0);
    pulse_start();
    send_bits(16'hFFFF, W, 1'b0);
    check("after abort word", 32'(word_o), 32'h0000FFFF);
    release_word();

    // Reset mid-word.
    pulse_start();
    send_bits(16'hFFFF, 10, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset word", 32'(word_o), 32'h0);
    check("midreset busy", 32'(busy_o), 32'h0);
    pulse_start();
    send_bits(16'h8001, W, 1'b0);
    check("after reset word", 32'(word_o), 32'h00008001);
    release_word();

    // Back-to-back words.
    pulse_start();
    send_bits(16'h3C3C, W, 1'b0);
    word_ready_i = 1'b1;
    start_i      = 1'b1;
    step();
    word_ready_i = 1'b0;
    start_i      = 1'b0;
    check("b2b busy", 32'(busy_o), 32'h1);
    check("b2b novalid", 32'(word_valid_o), 32'h0);
    send_bits(16'h0F0F, W, 1'b0);
    check("b2b word", 32'(word_o), 32'h00000F0F);
    check("b2b valid", 32'(word_valid_o), 32'h1);
    release_word();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      start_i      = ($urandom_range(0, 3) == 0);
      abort_i      = ($urandom_range(0, 39) == 0);
      bit_valid_i  = ($urandom_range(0, 1) == 1);
      serial_i     = ($urandom_range(0, 1) == 1);
      word_ready_i = ($urandom_range(0, 2) == 0);
      step();
    end
    reset        = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    bit_valid_i  = 1'b0;
    word_ready_i = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
